// File: rtl/pipeline_defs.sv
// Shared pipeline definitions: bubble instruction, fetch FSM encodings and IF/ID entry layout.
package pipeline_defs;

  localparam int unsigned XLEN         = 32;
  localparam int unsigned INSTR_W      = 32;
  localparam logic [INSTR_W-1:0] NOP_INSTR_DEF = 32'h0000_0013;

  typedef enum logic [1:0] {
    ST_RUN   = 2'd0,
    ST_STALL = 2'd1,
    ST_REDIR = 2'd2
  } fetch_state_e;

  typedef struct packed {
    logic [XLEN-1:0]    pc;
    logic [INSTR_W-1:0] instr;
    logic               valid;
  } ifid_entry_t;

  function automatic ifid_entry_t make_bubble(input logic [INSTR_W-1:0] nop);
    ifid_entry_t e;
    e.pc    = '0;
    e.instr = nop;
    e.valid = 1'b0;
    return e;
  endfunction

endpackage

// File: rtl/sat_counter32.sv
// Enable-driven 32-bit counter that sticks at all-ones.
module sat_counter32 (
  input  logic        clk,
  input  logic        rst,
  input  logic        en_i,
  output logic [31:0] count_o
);

  logic [31:0] cnt_q, cnt_d;

  always_comb begin
    cnt_d = cnt_q;
    if (en_i && (cnt_q != 32'hFFFF_FFFF)) cnt_d = cnt_q + 32'd1;
  end

  always_ff @(posedge clk) begin
    if (rst) cnt_q <= '0;
    else     cnt_q <= cnt_d;
  end

  assign count_o = cnt_q;

endmodule

// File: rtl/fetch_stage.sv
// Instruction fetch stage with stall skid entry and flush redirect.
// Optional perf counters enabled by FETCH_PERF_CNT_EN.
module fetch_stage
  import pipeline_defs::*;
#(
  parameter logic [31:0] RESET_PC  = 32'h0000_0000,
  parameter logic [31:0] NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        stall_IFID,
  input  logic        flush,
  input  logic [31:0] branch_target,
  output logic [31:0] imem_addr,
  input  logic [31:0] imem_rdata,
  output logic [31:0] pc_ID,
  output logic [31:0] instr_ID,
  output logic        valid_ID,
  output logic [31:0] stall_count,
  output logic [31:0] flush_count
);

  fetch_state_e state_q, state_d;
  logic [XLEN-1:0] pc_f_q, pc_f_d;
  logic [XLEN-1:0] fetch_pc_q, fetch_pc_d;
  ifid_entry_t     hold_q, hold_d;
  ifid_entry_t     ifid_q, ifid_d;
  ifid_entry_t     new_entry, bubble;
  logic [XLEN-1:0] pc_inc;
  logic            unused_bt;

  assign unused_bt = ^branch_target[1:0];
  assign new_entry = '{pc: fetch_pc_q, instr: imem_rdata, valid: 1'b1};
  assign bubble    = make_bubble(NOP_INSTR);
  assign pc_inc    = pc_f_q + 32'd4;

  always_ff @(posedge clock) begin
    if (reset) state_q <= ST_REDIR;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d = state_q;
    if (flush) begin
      state_d = ST_REDIR;
    end else begin
      case (state_q)
        ST_RUN:   if (stall_IFID)  state_d = ST_STALL;
        ST_STALL: if (!stall_IFID) state_d = ST_RUN;
        ST_REDIR: state_d = stall_IFID ? ST_STALL : ST_RUN;
        default:  state_d = ST_REDIR;
      endcase
    end
  end

  // Datapath next values; a flush overrides any stall in the same cycle.
  always_comb begin
    pc_f_d     = pc_f_q;
    fetch_pc_d = fetch_pc_q;
    hold_d     = hold_q;
    ifid_d     = ifid_q;
    if (flush) begin
      ifid_d       = bubble;
      hold_d.valid = 1'b0;
      pc_f_d       = {branch_target[31:2], 2'b00};
    end else begin
      case (state_q)
        ST_RUN: begin
          fetch_pc_d = pc_f_q;
          if (stall_IFID) begin
            hold_d = new_entry;
          end else begin
            ifid_d = new_entry;
            pc_f_d = pc_inc;
          end
        end
        ST_STALL: begin
          if (!stall_IFID) begin
            ifid_d = hold_q;
            pc_f_d = pc_inc;
          end
        end
        ST_REDIR: begin
          // Data returning now belongs to the pre-redirect address and is dropped.
          fetch_pc_d = pc_f_q;
          if (stall_IFID) begin
            hold_d = bubble;
          end else begin
            ifid_d = bubble;
            pc_f_d = pc_inc;
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      pc_f_q     <= RESET_PC;
      fetch_pc_q <= '0;
      hold_q     <= '0;
      ifid_q     <= bubble;
    end else begin
      pc_f_q     <= pc_f_d;
      fetch_pc_q <= fetch_pc_d;
      hold_q     <= hold_d;
      ifid_q     <= ifid_d;
    end
  end

  assign imem_addr = pc_f_q;
  assign pc_ID     = ifid_q.pc;
  assign instr_ID  = ifid_q.instr;
  assign valid_ID  = ifid_q.valid;

`ifdef FETCH_PERF_CNT_EN
  sat_counter32 u_stall_cnt (
    .clk     (clock),
    .rst     (reset),
    .en_i    (stall_IFID & ~flush),
    .count_o (stall_count)
  );

  sat_counter32 u_flush_cnt (
    .clk     (clock),
    .rst     (reset),
    .en_i    (flush),
    .count_o (flush_count)
  );
`else
  assign stall_count = 32'h0;
  assign flush_count = 32'h0;
`endif

endmodule

// File: tb/tb_fetch_stage.sv
// Directed self-checking bench for fetch_stage; memory model returns word index (addr>>2).
module tb_fetch_stage;
  import pipeline_defs::*;

`ifdef FETCH_PERF_CNT_EN
  localparam bit PERF = 1'b1;
`else
  localparam bit PERF = 1'b0;
`endif

  logic        clock = 1'b0;
  logic        reset = 1'b1;
  logic        stall_IFID = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] branch_target = 32'h0;
  logic [31:0] imem_addr, imem_rdata, pc_ID, instr_ID, stall_count, flush_count;
  logic        valid_ID;
  logic [31:0] w_addr, w_rdata, w_pc, w_instr, w_scnt, w_fcnt;
  logic        w_valid;

  int total = 0;
  int bad   = 0;

  always #5 clock = ~clock;

  always_ff @(posedge clock) begin
    imem_rdata <= imem_addr >> 2;
    w_rdata    <= w_addr >> 2;
  end

  fetch_stage dut (
    .clock(clock), .reset(reset), .stall_IFID(stall_IFID), .flush(flush),
    .branch_target(branch_target), .imem_addr(imem_addr), .imem_rdata(imem_rdata),
    .pc_ID(pc_ID), .instr_ID(instr_ID), .valid_ID(valid_ID),
    .stall_count(stall_count), .flush_count(flush_count)
  );

  fetch_stage #(.RESET_PC(32'hFFFF_FFF8)) dut_w (
    .clock(clock), .reset(reset), .stall_IFID(stall_IFID), .flush(flush),
    .branch_target(branch_target), .imem_addr(w_addr), .imem_rdata(w_rdata),
    .pc_ID(w_pc), .instr_ID(w_instr), .valid_ID(w_valid),
    .stall_count(w_scnt), .flush_count(w_fcnt)
  );

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic do_reset();
    reset = 1'b1;
    tick();
    tick();
    reset = 1'b0;
  endtask

  task automatic check_reset_state(input string tag);
    check({tag, "_addr"},  imem_addr, 32'h0);
    check({tag, "_pc"},    pc_ID, 32'h0);
    check({tag, "_instr"}, instr_ID, 32'h0000_0013);
    check({tag, "_valid"}, 32'(valid_ID), 32'h0);
    check({tag, "_scnt"},  stall_count, 32'h0);
    check({tag, "_fcnt"},  flush_count, 32'h0);
  endtask

  initial begin
    // Reset values and straight-line fetch, plus wrap on the second instance
    do_reset();
    check_reset_state("rst");
    check("wrap_c0", w_addr, 32'hFFFF_FFF8);
    for (int k = 1; k <= 6; k++) begin
      tick();
      check($sformatf("run_addr_c%0d", k), imem_addr, 32'(4 * k));
      if (k >= 2) begin
        check($sformatf("run_pc_c%0d", k),    pc_ID, 32'(4 * (k - 2)));
        check($sformatf("run_instr_c%0d", k), instr_ID, 32'(k - 2));
        check($sformatf("run_valid_c%0d", k), 32'(valid_ID), 32'h1);
      end else begin
        check("run_valid_c1", 32'(valid_ID), 32'h0);
        check("wrap_c1", w_addr, 32'hFFFF_FFFC);
      end
      if (k == 2) check("wrap_c2", w_addr, 32'h0000_0000);
    end

    // Three-cycle stall while pc_ID = 0x8
    do_reset();
    for (int k = 1; k <= 4; k++) tick();
    check("stl_pre_pc", pc_ID, 32'h8);
    stall_IFID = 1'b1;
    for (int k = 5; k <= 7; k++) begin
      tick();
      check($sformatf("stl_pc_c%0d", k),   pc_ID, 32'h8);
      check($sformatf("stl_addr_c%0d", k), imem_addr, 32'h10);
    end
    stall_IFID = 1'b0;
    tick();
    check("stl_rel_pc",    pc_ID, 32'hC);
    check("stl_rel_instr", instr_ID, 32'h3);
    check("stl_rel_valid", 32'(valid_ID), 32'h1);
    check("stl_rel_addr",  imem_addr, 32'h14);
    tick();
    check("stl_nxt_pc",    pc_ID, 32'h10);
    check("stl_nxt_instr", instr_ID, 32'h4);
    check("stl_scnt",      stall_count, PERF ? 32'd3 : 32'd0);

    // Flush with simultaneous stall: flush wins, unaligned target is rounded down
    flush = 1'b1;
    stall_IFID = 1'b1;
    branch_target = 32'h103;
    tick();
    flush = 1'b0;
    stall_IFID = 1'b0;
    check("fl_n1_addr",  imem_addr, 32'h100);
    check("fl_n1_valid", 32'(valid_ID), 32'h0);
    check("fl_n1_instr", instr_ID, 32'h0000_0013);
    check("fl_fcnt",     flush_count, PERF ? 32'd1 : 32'd0);
    check("fl_scnt",     stall_count, PERF ? 32'd3 : 32'd0);
    tick();
    check("fl_n2_valid", 32'(valid_ID), 32'h0);
    check("fl_n2_addr",  imem_addr, 32'h104);
    tick();
    check("fl_n3_valid", 32'(valid_ID), 32'h1);
    check("fl_n3_pc",    pc_ID, 32'h100);
    check("fl_n3_instr", instr_ID, 32'h40);
    tick();
    check("fl_n4_pc",    pc_ID, 32'h104);
    check("fl_n4_instr", instr_ID, 32'h41);

    // Reset during a two-cycle stall discards held data
    stall_IFID = 1'b1;
    tick();
    tick();
    reset = 1'b1;
    tick();
    reset = 1'b0;
    stall_IFID = 1'b0;
    check_reset_state("rst_stl");
    tick();
    check("rst_stl_c1_valid", 32'(valid_ID), 32'h0);
    check("rst_stl_c1_addr",  imem_addr, 32'h4);
    tick();
    check("rst_stl_c2_pc",    pc_ID, 32'h0);
    check("rst_stl_c2_instr", instr_ID, 32'h0);
    check("rst_stl_c2_valid", 32'(valid_ID), 32'h1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
